// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN adds the TRAP state.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_HOLD  = 2'b01,
        ST_DRAIN = 2'b10
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        ST_TRAP  = 2'b11
`endif
    } fetch_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_pc_reg.sv
// Fetch address register: synchronous clear to RESET_PC, load wins over increment.
module fetch_pc_reg
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Clear,
    input  logic        load_i,
    input  logic [31:0] load_pc_i,
    input  logic        incr_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (incr_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge Clk) begin
        if (Clear) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over req/ack, hands words to decode over valid/ready.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (sticky misaligned-target trap).
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Clear,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misaligned
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pending_q, pending_d;
    logic [31:0]  instr_q;
    logic [31:0]  pc_q;
    logic [31:0]  fetch_pc;
    logic [31:0]  target;
    logic [31:0]  load_pc;
    logic         load;
    logic         incr;
    logic         capture;
    logic         redir_bad;
    logic         misaligned_q;

    assign target = align_pc(redirect_pc);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_bad = redirect && (redirect_pc[1:0] != 2'b00) && (state_q != ST_TRAP);

    always_ff @(posedge Clk) begin
        if (Clear) begin
            misaligned_q <= 1'b0;
        end else if (redir_bad) begin
            misaligned_q <= 1'b1;
        end
    end
`else
    assign redir_bad    = 1'b0;
    assign misaligned_q = 1'b0;
`endif

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_fetch_pc_reg (
        .Clk       (Clk),
        .Clear     (Clear),
        .load_i    (load),
        .load_pc_i (load_pc),
        .incr_i    (incr),
        .pc_o      (fetch_pc)
    );

    always_ff @(posedge Clk) begin
        if (Clear) begin
            state_q   <= ST_FETCH;
            pending_q <= RESET_PC;
            instr_q   <= 32'h0000_0000;
            pc_q      <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (capture) begin
                instr_q <= imem_rdata;
                pc_q    <= fetch_pc;
            end
        end
    end

    // Redirect outranks ack and ready; an in-flight request must finish before the new target is used.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        load      = 1'b0;
        load_pc   = target;
        incr      = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    if (imem_ack) begin
                        load    = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        pending_d = target;
                        state_d   = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    load    = 1'b1;
                    state_d = ST_FETCH;
                end else if (instr_ready) begin
                    incr    = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    pending_d = target;
                end
                if (imem_ack) begin
                    load    = 1'b1;
                    load_pc = redirect ? target : pending_q;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        // A bad target ends in TRAP as soon as no request is outstanding.
        if ((redir_bad || misaligned_q) && (state_d == ST_FETCH)) begin
            state_d = ST_TRAP;
        end
`endif
    end

    always_comb begin
        imem_req         = !Clear && ((state_q == ST_FETCH) || (state_q == ST_DRAIN));
        imem_addr        = fetch_pc;
        instr_valid      = (state_q == ST_HOLD);
        instruction      = instr_q;
        pc               = pc_q;
        fetch_misaligned = misaligned_q;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit with a decode-side scoreboard.
// Follows FETCH_MISALIGN_TRAP_EN to pick the expected misaligned-redirect behaviour.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Clear;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_misaligned;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .Clk              (Clk),
        .Clear            (Clear),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instruction      (instruction),
        .pc               (pc),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input logic [31:0] exp_addr);
        int n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        check("req_seen", imem_req, 32'd1);
        check("req_addr", imem_addr, exp_addr);
    endtask

    // Answer one fetch after lat cycles; keep=1 means decode should later see this word.
    task automatic serve(input logic [31:0] addr, input int lat, input logic [31:0] rdata, input bit keep);
        wait_req(addr);
        for (int i = 0; i < lat; i++) begin
            check("req_held", imem_req, 32'd1);
            check("addr_stable", imem_addr, addr);
            step();
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        if (keep) exp_q.push_back('{pc: addr, instr: rdata});
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        check("valid_seen", instr_valid, 32'd1);
    endtask

    task automatic accept(input int hold);
        exp_t e;
        wait_valid();
        check("sb_nonempty", exp_q.size() != 0, 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", instr_valid, 32'd1);
            check("hold_no_req", imem_req, 32'd0);
            check("hold_pc", pc, e.pc);
            check("hold_instr", instruction, e.instr);
            step();
        end
        check("sb_pc", pc, e.pc);
        check("sb_instr", instruction, e.instr);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("valid_drop", instr_valid, 32'd0);
    endtask

    initial begin
        Clear       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        step();
        step();
        check("rst_req", imem_req, 32'd0);
        check("rst_valid", instr_valid, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_misaligned", fetch_misaligned, 32'd0);
        Clear = 1'b0;
        step();

        // Sequential fetch of NOPs at 0, 4, 8
        for (int i = 0; i < 3; i++) begin
            serve(32'(i * 4), 1, NOP, 1'b1);
            accept(0);
        end

        // Decode stalls for 5 cycles
        serve(32'h0000_000C, 1, 32'hA0A0_0013, 1'b1);
        accept(5);

        // Redirect in HOLD beats instr_ready
        serve(32'h0000_0010, 2, 32'hDEAD_0001, 1'b0);
        wait_valid();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        instr_ready = 1'b1;
        step();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        check("hold_redir_valid", instr_valid, 32'd0);
        serve(32'h0000_0100, 1, 32'h0011_2233, 1'b1);
        accept(0);

        // Redirect while a request is in flight, ack 3 cycles later
        wait_req(32'h0000_0104);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("drain_req", imem_req, 32'd1);
            check("drain_addr", imem_addr, 32'h0000_0104);
            step();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_0002;
        step();
        imem_ack = 1'b0;
        check("drain_discard", instr_valid, 32'd0);
        serve(32'h0000_0200, 1, 32'h4455_6677, 1'b1);
        accept(0);

        // Redirect coincident with ack, then PC wraparound
        wait_req(32'h0000_0204);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        imem_ack    = 1'b1;
        imem_rdata  = 32'hDEAD_0003;
        step();
        redirect = 1'b0;
        imem_ack = 1'b0;
        check("ack_redir_discard", instr_valid, 32'd0);
        serve(32'hFFFF_FFFC, 1, 32'h8899_AABB, 1'b1);
        accept(0);
        wait_req(32'h0000_0000);
        check("wrap_misaligned", fetch_misaligned, 32'd0);

        // Two redirects during drain: the last one wins
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        step();
        redirect_pc = 32'h0000_0400;
        step();
        redirect = 1'b0;
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_0004;
        step();
        imem_ack = 1'b0;
        serve(32'h0000_0400, 1, 32'hCCDD_EEFF, 1'b1);
        accept(0);

        // Misaligned redirect target
        serve(32'h0000_0404, 1, 32'hDEAD_0005, 1'b0);
        wait_valid();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        instr_ready = 1'b1;
        step();
        redirect    = 1'b0;
        instr_ready = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            check("trap_flag", fetch_misaligned, 32'd1);
            check("trap_no_req", imem_req, 32'd0);
            check("trap_no_valid", instr_valid, 32'd0);
            redirect    = 1'b1;
            redirect_pc = 32'h0000_0500;
            imem_ack    = 1'b1;
            instr_ready = 1'b1;
            step();
        end
        redirect    = 1'b0;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        Clear       = 1'b1;
        step();
        check("trap_clear_flag", fetch_misaligned, 32'd0);
        Clear = 1'b0;
        step();
        wait_req(32'h0000_0000);
`else
        check("misalign_flag_off", fetch_misaligned, 32'd0);
        wait_req(32'h0000_0100);
`endif

        // Clear with a request outstanding
        Clear = 1'b1;
        step();
        check("clr_req", imem_req, 32'd0);
        check("clr_valid", instr_valid, 32'd0);
        check("clr_pc", pc, 32'h0);
        check("clr_instr", instruction, 32'h0);
        Clear = 1'b0;
        step();
        serve(32'h0000_0000, 1, 32'h1357_9BDF, 1'b1);
        accept(1);

        check("sb_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
